seg7_scan: RTL and testbench

- Time-multiplexed scan controller for the 8-digit common-anode 7-segment display.
- Sits directly upstream of the per-digit hex-to-segment decoder and drives its DIN/EN/DOT inputs plus the active-low digit anodes.
- Takes 8 packed BCD/hex nibbles from the stopwatch core and inserts a dead-time blank at the start of each digit slot to suppress ghosting.
- Performs leading-zero blanking and snapshots inputs once per frame so a frame never tears.

---
 rtl/seg7_scan.sv | 165 ++++++++++++++++
 tb/tb_seg7_scan.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Latency: all outputs are registered from the prescaler/index/shadow state, one cycle behind the counter.
// Backpressure: none; free-running scan. Inputs are sampled once per frame into shadow registers.
//
// Ports:
//   CLK   - system clock, rising edge
//   RST   - asynchronous active-high reset
//   DATA  - 8 packed nibbles, digit i = DATA[4i+3:4i], digit 0 rightmost
//   DOTS  - per-digit decimal point request
//   DIGEN - per-digit enable; a disabled digit stays dark
//   LZB   - leading-zero blanking enable
//   DIN   - nibble to the hex-to-segment decoder (always the current digit's value)
//   EN    - decoder enable, 0 blanks the segments
//   DOT   - decimal point request to the decoder
//   nAN   - active-low anode select, never more than one bit low
//   FRAME - one-cycle pulse marking the start of a new frame
module seg7_scan #(
  parameter int SCAN_DIV  = 50000,  // clock cycles per digit slot, >= 2
  parameter int BLANK_CYC = 500     // dead-time cycles at slot start, 1 <= BLANK_CYC < SCAN_DIV
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DATA,
  input  logic [7:0]  DOTS,
  input  logic [7:0]  DIGEN,
  input  logic        LZB,
  output logic [3:0]  DIN,
  output logic        EN,
  output logic        DOT,
  output logic [7:0]  nAN,
  output logic        FRAME
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  // Prescaler and digit index
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          first;

  // Per-frame snapshot of the inputs
  logic [31:0]   sdata;
  logic [7:0]    sdots;
  logic [7:0]    sdigen;
  logic          slzb;

  logic          wrap;       // last cycle of the current slot
  logic          frame_end;  // last cycle of slot 7
  logic          load;

  assign wrap      = (cnt == CNT_MAX);
  assign frame_end = wrap && (idx == 3'd7);
  // The very first frame after reset has no preceding wrap, so it is
  // snapshotted on the first cycle instead.
  assign load      = first | frame_end;

  // ---------------------------------------------------------------------
  // Prescaler / index
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= idx + 3'd1;  // 7 wraps naturally to 0
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Snapshot registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      first  <= 1'b1;
      sdata  <= '0;
      sdots  <= '0;
      sdigen <= '0;
      slzb   <= 1'b0;
    end else begin
      if (load) begin
        sdata  <= DATA;
        sdots  <= DOTS;
        sdigen <= DIGEN;
        slzb   <= LZB;
      end
      first <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Leading-zero blanking
  // A digit is "blankable" if it is disabled, or it is a zero without a dot.
  // The blank chain runs from digit 7 downward and stops at the first
  // non-blankable digit; digit 0 is always kept so a value of 0 still shows.
  // ---------------------------------------------------------------------
  logic [7:0] zero;
  logic [7:0] lz;
  logic       chain;

  always_comb begin
    zero  = '0;
    lz    = '0;
    chain = slzb;
    for (int j = 0; j < 8; j++) begin
      zero[j] = ~sdigen[j] | ((sdata[4*j +: 4] == 4'd0) & ~sdots[j]);
    end
    for (int i = 7; i >= 1; i--) begin
      chain = chain & zero[i];
      lz[i] = chain;
    end
  end

  // ---------------------------------------------------------------------
  // Next-output decode for the current slot/phase
  // ---------------------------------------------------------------------
  logic [3:0] nib;
  logic       vis;
  logic       in_blank;
  logic [3:0] din_nxt;
  logic       en_nxt;
  logic       dot_nxt;
  logic [7:0] nan_nxt;

  assign nib      = sdata[{idx, 2'b00} +: 4];
  assign vis      = sdigen[idx] & ~lz[idx];
  assign in_blank = (cnt < BLANK_END);

  always_comb begin
    din_nxt = nib;  // the decoder input follows the digit even while dark
    en_nxt  = 1'b0;
    dot_nxt = 1'b0;
    nan_nxt = 8'hFF;
    if (!in_blank) begin
      en_nxt       = vis;
      dot_nxt      = vis & sdots[idx];
      nan_nxt[idx] = ~vis;
    end
  end

  // ---------------------------------------------------------------------
  // Output registers. A single index drives the anode decode, so at most
  // one anode can ever be low.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DIN   <= 4'd0;
      EN    <= 1'b0;
      DOT   <= 1'b0;
      nAN   <= 8'hFF;
      FRAME <= 1'b0;
    end else begin
      DIN   <= din_nxt;
      EN    <= en_nxt;
      DOT   <= dot_nxt;
      nAN   <= nan_nxt;
      FRAME <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;

  localparam int SD = 8;
  localparam int BC = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] DATA = '0;
  logic [7:0]  DOTS = '0;
  logic [7:0]  DIGEN = '0;
  logic        LZB = 1'b0;
  logic [3:0]  DIN;
  logic        EN;
  logic        DOT;
  logic [7:0]  nAN;
  logic        FRAME;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .DOTS(DOTS), .DIGEN(DIGEN), .LZB(LZB),
    .DIN(DIN), .EN(EN), .DOT(DOT), .nAN(nAN), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dots;
    logic [7:0]  digen;
    logic        lzb;
    logic [7:0]  en;   // expected visible digits during DRIVE
    logic [7:0]  dot;  // expected decimal points during DRIVE
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, n, act, exp);
    end
  endtask

  // Pulse reset across one rising edge; sample reset values while held.
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst_nan", 0, nAN, 8'hFF);
    chk("rst_en", 0, EN, 0);
    chk("rst_dot", 0, DOT, 0);
    chk("rst_frame", 0, FRAME, 0);
    chk("rst_din", 0, DIN, 0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    int c, d;
    logic        e_en, e_dot, e_frm;
    logic [7:0]  e_nan;
    logic [3:0]  e_din;
    logic [31:0] dv;

    //            data          dots   digen  lzb   en     dot
    vecs[0] = '{32'h87654321, 8'h00, 8'hFF, 1'b0, 8'hFF, 8'h00};  // plain scan
    vecs[1] = '{32'h00000305, 8'h00, 8'hFF, 1'b1, 8'h07, 8'h00};  // LZB keeps inner zero
    vecs[2] = '{32'h00000005, 8'h02, 8'hFF, 1'b1, 8'h03, 8'h02};  // "0." stops blanking
    vecs[3] = '{32'h0000ABCD, 8'h80, 8'hFF, 1'b1, 8'hFF, 8'h80};  // dot on digit 7, hex passthrough
    vecs[4] = '{32'h12345678, 8'hFF, 8'h00, 8'b1, 8'h00, 8'h00};  // all digits disabled
    vecs[5] = '{32'hFEDCBA98, 8'hFF, 8'hA5, 1'b0, 8'hA5, 8'hA5};  // sparse enables
    vecs[6] = '{32'h00000120, 8'h00, 8'hFB, 1'b1, 8'h03, 8'h00};  // disabled digit inside blank chain

    for (int v = 0; v < 7; v++) begin
      DATA  = vecs[v].data;
      DOTS  = vecs[v].dots;
      DIGEN = vecs[v].digen;
      LZB   = vecs[v].lzb;
      do_reset();
      dv = vecs[v].data;
      // Output sampled after rising edge k reflects cnt=(k-1)%8, idx=(k-1)/8.
      for (int k = 1; k <= 129; k++) begin
        @(negedge CLK);
        c = (k - 1) % SD;
        d = ((k - 1) / SD) % 8;
        e_din = (k == 1) ? 4'd0 : dv[d*4 +: 4];
        if (c < BC) begin
          e_en = 1'b0; e_dot = 1'b0; e_nan = 8'hFF;
        end else begin
          e_en  = vecs[v].en[d];
          e_dot = vecs[v].dot[d];
          e_nan = e_en ? ~(8'h01 << d) : 8'hFF;
        end
        e_frm = (k % 64) == 0;
        chk("nan", k, nAN, e_nan);
        chk("en", k, EN, e_en);
        chk("dot", k, DOT, e_dot);
        chk("din", k, DIN, e_din);
        chk("frame", k, FRAME, e_frm);
        chk("one_anode", k, ($countones(~nAN) <= 1), 1);
      end
    end

    // Snapshot: input change mid-frame only shows from the next frame.
    DATA = 32'h11111111; DOTS = 8'h00; DIGEN = 8'hFF; LZB = 1'b0;
    do_reset();
    for (int k = 1; k <= 80; k++) begin
      @(negedge CLK);
      if (k == 30) DATA = 32'h22222222;  // idx=3 in progress
      if (k == 40) chk("snap_idx4", k, DIN, 4'd1);
      if (k == 60) chk("snap_idx7", k, DIN, 4'd1);
      if (k == 64) chk("snap_wrap", k, DIN, 4'd1);
      if (k == 64) chk("snap_frame", k, FRAME, 1);
      if (k == 66) chk("snap_new0", k, DIN, 4'd2);
      if (k == 75) chk("snap_new1", k, DIN, 4'd2);
      if (k == 75) chk("snap_en1", k, EN, 1);
    end

    // Asynchronous reset during DRIVE of slot 5.
    DATA = 32'h87654321;
    do_reset();
    for (int k = 1; k <= 45; k++) @(negedge CLK);
    chk("pre_nan5", 45, nAN, 8'hDF);
    chk("pre_en5", 45, EN, 1);
    #2;
    RST = 1'b1;
    #1;
    chk("async_nan", 45, nAN, 8'hFF);
    chk("async_en", 45, EN, 0);
    chk("async_frame", 45, FRAME, 0);
    chk("async_din", 45, DIN, 0);
    DATA = 32'h9ABCDEF7;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_din1", 1, DIN, 0);
    chk("post_nan1", 1, nAN, 8'hFF);
    @(negedge CLK);
    @(negedge CLK);
    chk("post_nan3", 3, nAN, 8'hFE);
    chk("post_en3", 3, EN, 1);
    chk("post_din3", 3, DIN, 4'h7);
    for (int k = 4; k <= 11; k++) @(negedge CLK);
    chk("post_nan11", 11, nAN, 8'hFD);
    chk("post_din11", 11, DIN, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
